dca_matrix_register_fill: RTL and testbench

Parametrised successor of the constant matrix register in the DCA tensor datapath. Holds a MATRIX_NUM_ROW x MATRIX_NUM_COL matrix of scalars. The matrix is filled by command:
- broadcast a scalar to every element,
- build a scaled identity (scalar on the diagonal, zero elsewhere),
- clear, or
- stream one row per cycle over a valid/ready handshake.

Downstream PEs read the full matrix and the upmost row combinationally from registers.

---
 rtl/dca_matrix_register_fill_pkg.sv | 32 +++
 rtl/dca_matrix_row_register.sv | 38 +++
 rtl/dca_matrix_register_fill.sv | 125 ++++++++++++
 tb/tb_dca_matrix_register_fill.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_register_fill_pkg.sv
// Shared encodings and width helpers for the DCA fill-by-command matrix register.
package dca_matrix_register_fill_pkg;

  typedef enum logic [1:0] {
    DCA_FILL_MODE_FILL   = 2'd0,
    DCA_FILL_MODE_DIAG   = 2'd1,
    DCA_FILL_MODE_CLEAR  = 2'd2,
    DCA_FILL_MODE_STREAM = 2'd3
  } fill_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fill_state_e;

  localparam int DEFAULT_MATRIX_SIZE = 8;
  localparam int DEFAULT_BW_SCALAR   = 32;

  function automatic int row_width(input int num_col, input int bw_scalar);
    return num_col * bw_scalar;
  endfunction

  function automatic int matrix_width(input int num_row, input int num_col, input int bw_scalar);
    return num_row * num_col * bw_scalar;
  endfunction

  // A single-row matrix still needs one counter bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dca_matrix_row_register.sv
// One matrix row: streamed write, scalar broadcast, clear and scaled-identity diagonal load.
module dca_matrix_row_register #(
  parameter int NUM_COL   = 8,
  parameter int BW_SCALAR = 32,
  parameter int IDX_W     = 3
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           wr_en,
  input  logic [NUM_COL*BW_SCALAR-1:0]   wr_data,
  input  logic                           bcast_en,
  input  logic [BW_SCALAR-1:0]           scalar,
  input  logic                           clear,
  input  logic                           diag_en,
  input  logic [IDX_W-1:0]               diag_index,
  output logic [NUM_COL*BW_SCALAR-1:0]   rdata
);

  logic [NUM_COL*BW_SCALAR-1:0] diag_row;

  for (genvar c = 0; c < NUM_COL; c++) begin : g_diag
    assign diag_row[c*BW_SCALAR +: BW_SCALAR] =
      (diag_index == IDX_W'(c)) ? scalar : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      rdata <= '0;
    end else if (wr_en) begin
      rdata <= wr_data;
    end else if (bcast_en) begin
      rdata <= {NUM_COL{scalar}};
    end else if (diag_en) begin
      rdata <= diag_row;
    end
  end

endmodule

// File: rtl/dca_matrix_register_fill.sv
// Command-filled constant matrix register (fill/diag/clear/row stream).
// Optional abort input for STREAM enabled by DCA_MATRIX_REGISTER_FILL_ABORT_EN.
module dca_matrix_register_fill
  import dca_matrix_register_fill_pkg::*;
#(
  parameter int MATRIX_SIZE_PARA = DEFAULT_MATRIX_SIZE,
  parameter int BW_TENSOR_SCALAR = DEFAULT_BW_SCALAR,
  localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA,
  localparam int MATRIX_NUM_COL   = MATRIX_SIZE_PARA,
  localparam int BW_TENSOR_ROW    = row_width(MATRIX_NUM_COL, BW_TENSOR_SCALAR),
  localparam int BW_TENSOR_MATRIX = matrix_width(MATRIX_NUM_ROW, MATRIX_NUM_COL, BW_TENSOR_SCALAR)
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_mode,
  input  logic [BW_TENSOR_SCALAR-1:0] cmd_scalar,
  input  logic                        row_wvalid,
  output logic                        row_wready,
  input  logic [BW_TENSOR_ROW-1:0]    row_wdata,
`ifdef DCA_MATRIX_REGISTER_FILL_ABORT_EN
  input  logic                        abort,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [BW_TENSOR_MATRIX-1:0] all_rdata_list2d,
  output logic [BW_TENSOR_ROW-1:0]    upmost_rdata_list1d
);

  localparam int CNT_W = cnt_width(MATRIX_NUM_ROW);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MATRIX_NUM_ROW - 1);

  fill_state_e      state, state_next;
  logic [CNT_W-1:0] counter, counter_next;
  logic             done_next;
  fill_mode_e       mode;
  logic             cmd_fire, row_fire;
  logic             fill_en, diag_en, clear_en;

  assign mode      = fill_mode_e'(cmd_mode);
  assign cmd_ready = (state == ST_IDLE);
  assign row_wready = (state == ST_STREAM);
  assign busy      = (state == ST_STREAM);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign row_fire  = row_wvalid && row_wready;
  assign fill_en   = cmd_fire && (mode == DCA_FILL_MODE_FILL);
  assign diag_en   = cmd_fire && (mode == DCA_FILL_MODE_DIAG);
  assign clear_en  = cmd_fire && (mode == DCA_FILL_MODE_CLEAR);

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state   <= ST_IDLE;
      counter <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    done_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (mode == DCA_FILL_MODE_STREAM) begin
            state_next   = ST_STREAM;
            counter_next = '0;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (row_fire) begin
          if (counter == LAST_ROW) begin
            state_next   = ST_IDLE;
            counter_next = '0;
            done_next    = 1'b1;
          end else begin
            counter_next = counter + 1'b1;
          end
        end
`ifdef DCA_MATRIX_REGISTER_FILL_ABORT_EN
        // Abort overrides completion; a row handshaked this cycle is still written.
        if (abort) begin
          state_next   = ST_IDLE;
          counter_next = '0;
          done_next    = 1'b0;
        end
`endif
      end
      default: begin
        state_next   = ST_IDLE;
        counter_next = '0;
      end
    endcase
  end

  for (genvar r = 0; r < MATRIX_NUM_ROW; r++) begin : g_row
    dca_matrix_row_register #(
      .NUM_COL   (MATRIX_NUM_COL),
      .BW_SCALAR (BW_TENSOR_SCALAR),
      .IDX_W     (CNT_W)
    ) u_row (
      .clk        (clk),
      .rstnn      (rstnn),
      .wr_en      (row_fire && (counter == CNT_W'(r))),
      .wr_data    (row_wdata),
      .bcast_en   (fill_en),
      .scalar     (cmd_scalar),
      .clear      (clear_en),
      .diag_en    (diag_en),
      .diag_index (CNT_W'(r)),
      .rdata      (all_rdata_list2d[r*BW_TENSOR_ROW +: BW_TENSOR_ROW])
    );
  end

  assign upmost_rdata_list1d = all_rdata_list2d[BW_TENSOR_ROW-1:0];

endmodule

// File: tb/tb_dca_matrix_register_fill.sv
// Self-checking bench for dca_matrix_register_fill (4x4 matrix of 8-bit scalars).
module tb_dca_matrix_register_fill;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam logic [1:0] M_FILL   = 2'd0;
  localparam logic [1:0] M_DIAG   = 2'd1;
  localparam logic [1:0] M_CLEAR  = 2'd2;
  localparam logic [1:0] M_STREAM = 2'd3;

  logic          clk;
  logic          rstnn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [7:0]    cmd_scalar;
  logic          row_wvalid;
  logic          row_wready;
  logic [31:0]   row_wdata;
  logic          busy;
  logic          done;
  logic [127:0]  all_rdata_list2d;
  logic [31:0]   upmost_rdata_list1d;
`ifdef DCA_MATRIX_REGISTER_FILL_ABORT_EN
  logic          abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: matrix contents plus whether a stream is in progress.
  logic [7:0] mdl [N][N];
  bit         mdl_streaming = 0;
  int         mdl_next_row  = 0;
  bit         mdl_done      = 0;
  bit         mdl_valid     = 0;

  dca_matrix_register_fill #(
    .MATRIX_SIZE_PARA (N),
    .BW_TENSOR_SCALAR (BW)
  ) dut (
    .clk                 (clk),
    .rstnn               (rstnn),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_mode            (cmd_mode),
    .cmd_scalar          (cmd_scalar),
    .row_wvalid          (row_wvalid),
    .row_wready          (row_wready),
    .row_wdata           (row_wdata),
`ifdef DCA_MATRIX_REGISTER_FILL_ABORT_EN
    .abort               (abort),
`endif
    .busy                (busy),
    .done                (done),
    .all_rdata_list2d    (all_rdata_list2d),
    .upmost_rdata_list1d (upmost_rdata_list1d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic modelStep();
    if (!rstnn) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mdl[r][c] = 8'h00;
      mdl_streaming = 0;
      mdl_next_row  = 0;
      mdl_done      = 0;
      mdl_valid     = 1;
    end else begin
      mdl_done = 0;
      if (!mdl_streaming) begin
        if (cmd_valid) begin
          case (cmd_mode)
            M_FILL: begin
              for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) mdl[r][c] = cmd_scalar;
              mdl_done = 1;
            end
            M_DIAG: begin
              for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) mdl[r][c] = (r == c) ? cmd_scalar : 8'h00;
              mdl_done = 1;
            end
            M_CLEAR: begin
              for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) mdl[r][c] = 8'h00;
              mdl_done = 1;
            end
            default: begin
              mdl_streaming = 1;
              mdl_next_row  = 0;
            end
          endcase
        end
      end else begin
        if (row_wvalid) begin
          for (int c = 0; c < N; c++) mdl[mdl_next_row][c] = row_wdata[c*BW +: BW];
          mdl_next_row++;
          if (mdl_next_row == N) begin
            mdl_streaming = 0;
            mdl_next_row  = 0;
            mdl_done      = 1;
          end
        end
`ifdef DCA_MATRIX_REGISTER_FILL_ABORT_EN
        if (abort) begin
          mdl_streaming = 0;
          mdl_next_row  = 0;
          mdl_done      = 0;
        end
`endif
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  initial begin
    logic [127:0] exp_all;
    forever begin
      @(negedge clk);
      if (mdl_valid) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) exp_all[(r*N+c)*BW +: BW] = mdl[r][c];
        checkOutput("model_all_rdata", all_rdata_list2d, exp_all);
        checkOutput("model_upmost", {96'h0, upmost_rdata_list1d}, {96'h0, exp_all[31:0]});
        checkOutput("model_cmd_ready", {127'h0, cmd_ready}, {127'h0, !mdl_streaming});
        checkOutput("model_row_wready", {127'h0, row_wready}, {127'h0, mdl_streaming});
        checkOutput("model_busy", {127'h0, busy}, {127'h0, mdl_streaming});
        checkOutput("model_done", {127'h0, done}, {127'h0, mdl_done});
      end
    end
  end

  task automatic applyStimulus(input bit cv, input logic [1:0] mode, input logic [7:0] scalar,
                               input bit rv, input logic [31:0] rdata);
    cmd_valid  = cv;
    cmd_mode   = mode;
    cmd_scalar = scalar;
    row_wvalid = rv;
    row_wdata  = rdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b0, 32'h0);
  endtask

  initial begin
    rstnn      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_mode   = M_FILL;
    cmd_scalar = 8'h00;
    row_wvalid = 1'b0;
    row_wdata  = 32'h0;
`ifdef DCA_MATRIX_REGISTER_FILL_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;

    checkOutput("reset_all", all_rdata_list2d, 128'h0);
    checkOutput("reset_cmd_ready", {127'h0, cmd_ready}, 128'h1);
    checkOutput("reset_done", {127'h0, done}, 128'h0);

    applyStimulus(1'b1, M_FILL, 8'h5A, 1'b0, 32'h0);
    checkOutput("fill_all", all_rdata_list2d, {16{8'h5A}});
    checkOutput("fill_upmost", {96'h0, upmost_rdata_list1d}, {96'h0, 32'h5A5A5A5A});
    checkOutput("fill_done", {127'h0, done}, 128'h1);
    idleCycle();
    checkOutput("fill_done_drop", {127'h0, done}, 128'h0);

    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'hDEADBEEF);
    checkOutput("idle_row_ignored", all_rdata_list2d, {16{8'h5A}});

    applyStimulus(1'b1, M_DIAG, 8'h03, 1'b0, 32'h0);
    checkOutput("diag_all", all_rdata_list2d,
                128'h03000000_00030000_00000300_00000003);
    checkOutput("diag_row0", {96'h0, upmost_rdata_list1d}, {96'h0, 32'h00000003});
    checkOutput("diag_done", {127'h0, done}, 128'h1);

    applyStimulus(1'b1, M_STREAM, 8'h00, 1'b0, 32'h0);
    checkOutput("stream_busy", {127'h0, busy}, 128'h1);
    checkOutput("stream_no_done", {127'h0, done}, 128'h0);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'h04030201);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'h08070605);
    applyStimulus(1'b1, M_FILL, 8'h77, 1'b0, 32'h0);
    applyStimulus(1'b1, M_FILL, 8'h77, 1'b0, 32'h0);
    checkOutput("bubble_cmd_ignored", all_rdata_list2d,
                128'h03000000_00030000_08070605_04030201);
    checkOutput("bubble_cmd_ready", {127'h0, cmd_ready}, 128'h0);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'h0C0B0A09);
    checkOutput("stream_not_done_yet", {127'h0, done}, 128'h0);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'h100F0E0D);
    checkOutput("stream_all", all_rdata_list2d,
                128'h100F0E0D_0C0B0A09_08070605_04030201);
    checkOutput("stream_done", {127'h0, done}, 128'h1);
    checkOutput("stream_exit_busy", {127'h0, busy}, 128'h0);

    applyStimulus(1'b1, M_FILL, 8'hFF, 1'b0, 32'h0);
    checkOutput("fill_in_done_all", all_rdata_list2d, {16{8'hFF}});
    checkOutput("fill_in_done_done", {127'h0, done}, 128'h1);
    applyStimulus(1'b1, M_FILL, 8'h12, 1'b0, 32'h0);
    checkOutput("fill_b2b_done", {127'h0, done}, 128'h1);
    applyStimulus(1'b1, M_CLEAR, 8'h99, 1'b0, 32'h0);
    checkOutput("clear_all", all_rdata_list2d, 128'h0);
    idleCycle();

    applyStimulus(1'b1, M_FILL, 8'h66, 1'b0, 32'h0);
    applyStimulus(1'b1, M_STREAM, 8'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'h11111111);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'h22222222);
    rstnn = 1'b0;
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'h33333333);
    rstnn = 1'b1;
    checkOutput("midreset_all", all_rdata_list2d, 128'h0);
    checkOutput("midreset_cmd_ready", {127'h0, cmd_ready}, 128'h1);
    checkOutput("midreset_done", {127'h0, done}, 128'h0);
    idleCycle();

`ifdef DCA_MATRIX_REGISTER_FILL_ABORT_EN
    applyStimulus(1'b1, M_FILL, 8'h11, 1'b0, 32'h0);
    applyStimulus(1'b1, M_STREAM, 8'h00, 1'b0, 32'h0);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'hA4A3A2A1);
    applyStimulus(1'b0, M_FILL, 8'h00, 1'b1, 32'hB4B3B2B1);
    abort = 1'b1;
    idleCycle();
    abort = 1'b0;
    checkOutput("abort_all", all_rdata_list2d,
                128'h11111111_11111111_B4B3B2B1_A4A3A2A1);
    checkOutput("abort_no_done", {127'h0, done}, 128'h0);
    checkOutput("abort_idle", {127'h0, cmd_ready}, 128'h1);
    abort = 1'b1;
    idleCycle();
    abort = 1'b0;
    checkOutput("abort_in_idle_ignored", all_rdata_list2d,
                128'h11111111_11111111_B4B3B2B1_A4A3A2A1);
`endif

    repeat (2) idleCycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
